// File: rtl/tank_motion_ctrl.sv
// tank_motion_ctrl: per-frame tank move/collision/fire controller, one instance per player.
// A frame tick starts a fixed 7-cycle sequence: it computes the candidate, checks the bounds and four wall corners, then commits.
module tank_motion_ctrl #(
    parameter int         START_X   = 64,
    parameter int         START_Y   = 64,
    parameter int         STEP      = 1,
    parameter int         COOLDOWN  = 30,
    parameter logic [7:0] KEY_UP    = 8'h1A,
    parameter logic [7:0] KEY_RIGHT = 8'h07,
    parameter logic [7:0] KEY_DOWN  = 8'h16,
    parameter logic [7:0] KEY_LEFT  = 8'h04,
    parameter logic [7:0] KEY_FIRE  = 8'h2C
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_clk,
    input  logic [7:0]   keycode,
    input  logic [299:0] wall_map,
    output logic [9:0]   TankX,
    output logic [9:0]   TankY,
    output logic [1:0]   TankDir,
    output logic         fire_pulse,
    output logic         busy
);
    typedef enum logic [2:0] {IDLE, CALC, CHK0, CHK1, CHK2, CHK3, UPD} state_e;
    state_e              state_q, state_d;
    logic [2:0]          sync_q;
    logic                frame_tick, go_q, blk_q, fire_q, oob, hit;
    logic [7:0]          key_q;
    logic signed [10:0]  cx_q, cy_q, cx_d, cy_d, step_s;
    logic [9:0]          x_q, y_q, px, py;
    logic [1:0]          dir_q, corner;
    logic [15:0]         cd_q;
    logic [8:0]          idx;

    assign frame_tick = sync_q[1] & ~sync_q[2];
    assign step_s     = 11'(STEP);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // go_q delays the start by one cycle so busy spans CALC..UPD only
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = go_q ? CALC : IDLE;
            UPD:     state_d = IDLE;
            default: state_d = state_e'(state_q + 3'd1);
        endcase
    end

    always_comb begin
        TankX      = x_q;
        TankY      = y_q;
        TankDir    = dir_q;
        fire_pulse = fire_q;
        busy       = state_q != IDLE;
    end

    always_comb begin
        cx_d   = $signed({1'b0, x_q}) + (key_q == KEY_RIGHT ? step_s : key_q == KEY_LEFT ? -step_s : 11'sd0);
        cy_d   = $signed({1'b0, y_q}) + (key_q == KEY_DOWN ? step_s : key_q == KEY_UP ? -step_s : 11'sd0);
        oob    = cx_d < 11'sd0 || cy_d < 11'sd0 || cx_d > 11'sd608 || cy_d > 11'sd448;
        corner = 2'(state_q - CHK0);
        px     = 10'(cx_q) + (corner[0] ? 10'd31 : 10'd0);
        py     = 10'(cy_q) + (corner[1] ? 10'd31 : 10'd0);
        idx    = blk_q ? 9'd0 : 9'({4'd0, py[9:5]} * 9'd20) + {4'd0, px[9:5]};
        hit    = !blk_q && wall_map[idx];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= '0;
            go_q   <= 1'b0;
            key_q  <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            blk_q  <= 1'b0;
            x_q    <= 10'(START_X);
            y_q    <= 10'(START_Y);
            dir_q  <= 2'd0;
            fire_q <= 1'b0;
            cd_q   <= '0;
        end else begin
            sync_q <= {sync_q[1:0], frame_clk};
            go_q   <= state_q == IDLE && frame_tick;
            fire_q <= 1'b0;
            if (state_q == IDLE && frame_tick) key_q <= keycode;
            if (state_q == CALC) begin
                cx_q  <= cx_d;
                cy_q  <= cy_d;
                blk_q <= oob;
            end else if (state_q inside {CHK0, CHK1, CHK2, CHK3}) begin
                blk_q <= blk_q | hit;
            end else if (state_q == UPD) begin
                if (!blk_q) begin
                    x_q <= 10'(cx_q);
                    y_q <= 10'(cy_q);
                end
                dir_q <= key_q == KEY_UP ? 2'd0 : key_q == KEY_RIGHT ? 2'd1 :
                         key_q == KEY_DOWN ? 2'd2 : key_q == KEY_LEFT ? 2'd3 : dir_q;
                if (cd_q != 16'd0) begin
                    cd_q <= cd_q - 16'd1;
                end else if (key_q == KEY_FIRE) begin
                    fire_q <= 1'b1;
                    cd_q   <= 16'(COOLDOWN);
                end
            end
        end
    end
endmodule

// File: tb/tb_tank_motion_ctrl.sv
// tb_tank_motion_ctrl: directed checks of movement, walls, screen edges, fire cooldown and reset abort.
module tb_tank_motion_ctrl;
    logic         clk = 1'b0, rst = 1'b0, frame_clk = 1'b0;
    logic [7:0]   keycode = 8'h00;
    logic [299:0] wall_map = '0;
    logic [9:0]   tx, ty, ax, ay, bx, by;
    logic [1:0]   td, ad, bd;
    logic         fp, bz, afp, abz, bfp, bbz;
    int           n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    tank_motion_ctrl dut (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode), .wall_map(wall_map),
        .TankX(tx), .TankY(ty), .TankDir(td), .fire_pulse(fp), .busy(bz)
    );
    tank_motion_ctrl #(.START_X(0), .START_Y(0)) dut_lo (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode), .wall_map(wall_map),
        .TankX(ax), .TankY(ay), .TankDir(ad), .fire_pulse(afp), .busy(abz)
    );
    tank_motion_ctrl #(.START_X(608), .START_Y(448)) dut_hi (
        .Clk(clk), .Reset(rst), .frame_clk(frame_clk), .keycode(keycode), .wall_map(wall_map),
        .TankX(bx), .TankY(by), .TankDir(bd), .fire_pulse(bfp), .busy(bbz)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One complete frame; returns the number of cycles fire_pulse was seen high
    task automatic frame(input logic [7:0] k, output int pulses);
        pulses = 0;
        keycode = k;
        frame_clk = 1'b1;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(fp);
        end
        frame_clk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(fp);
        end
    endtask

    initial begin
        int p, first_move, first_busy, busy_cnt;
        @(negedge clk);
        do_reset();
        check("rst_x", tx, 64);
        check("rst_y", ty, 64);
        check("rst_dir", td, 0);
        check("rst_busy", bz, 0);
        check("rst_fire", fp, 0);

        // Latency: frame_clk rises before posedge 1; commit lands on posedge 10
        first_move = 0; first_busy = 0; busy_cnt = 0;
        keycode = 8'h07;
        frame_clk = 1'b1;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (i == 5) keycode = 8'h04;
            if (bz) busy_cnt++;
            if (bz && first_busy == 0) first_busy = i;
            if (tx == 10'd65 && first_move == 0) first_move = i;
        end
        frame_clk = 1'b0;
        repeat (3) @(negedge clk);
        check("lat_move", first_move, 10);
        check("lat_busy_start", first_busy, 4);
        check("busy_cycles", busy_cnt, 6);
        check("move_x", tx, 65);
        check("move_y", ty, 64);
        check("move_dir", td, 1);

        // Reset during CHK2 aborts with no commit
        do_reset();
        keycode = 8'h07;
        frame_clk = 1'b1;
        repeat (7) @(negedge clk);
        check("mid_busy_before", bz, 1);
        rst = 1'b1;
        frame_clk = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_x", tx, 64);
        check("mid_dir", td, 0);
        check("mid_busy", bz, 0);
        frame(8'h07, p);
        check("after_mid_x", tx, 65);

        // Walls
        do_reset();
        wall_map[43] = 1'b1;
        frame(8'h07, p);
        check("wall_x", tx, 64);
        check("wall_dir", td, 1);
        wall_map[43] = 1'b0;
        frame(8'h07, p);
        check("wall_cleared_x", tx, 65);
        wall_map[62] = 1'b1;
        frame(8'h16, p);
        check("wall_down_y", ty, 64);
        check("wall_down_dir", td, 2);
        frame(8'h1A, p);
        check("up_y", ty, 63);
        check("up_dir", td, 0);
        frame(8'h00, p);
        check("nokey_x", tx, 65);
        check("nokey_dir", td, 0);
        wall_map = '0;

        // Screen edges
        do_reset();
        frame(8'h07, p);
        check("hi_right_x", bx, 608);
        check("hi_right_dir", bd, 1);
        check("lo_right_x", ax, 1);
        do_reset();
        frame(8'h04, p);
        check("lo_left_x", ax, 0);
        check("lo_left_dir", ad, 3);
        check("hi_left_x", bx, 607);
        frame(8'h1A, p);
        check("lo_up_y", ay, 0);
        check("lo_up_dir", ad, 0);
        frame(8'h16, p);
        check("hi_down_y", by, 448);
        check("hi_down_dir", bd, 2);

        // Fire cooldown: shots on frames 1 and 32 only
        do_reset();
        for (int f = 1; f <= 40; f++) begin
            frame(8'h2C, p);
            check($sformatf("fire_f%0d", f), p, (f == 1 || f == 32) ? 1 : 0);
        end
        check("fire_x", tx, 64);
        check("fire_dir", td, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
